// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard to switching-matrix emulator.
// Receives PS/2 frames, decodes E0/F0/E1 prefixes, maps {ext, scancode}
// through a host-loadable map RAM to a matrix bit and keeps an active-low
// ROWS x COLS key matrix readable by the emulated machine's row scanner.
module ps2_matrix_kbd #(
    parameter int         ROWS       = 10,
    parameter int         COLS       = 8,
    parameter int         RW         = 4,
    parameter int         CW         = 3,
    parameter int         FILT       = 4,
    parameter int         TOUT_W     = 12,
    parameter logic [7:0] RESET_CODE = 8'h7E,
    parameter logic       RESET_EXT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kclk,
    input  logic             kdat,
    input  logic [RW-1:0]    a,
    output logic [COLS-1:0]  row,
    input  logic             map_we,
    input  logic [8:0]       map_addr,
    input  logic [RW+CW-1:0] map_data,
    output logic             resetk,
    output logic             code_vld,
    output logic [7:0]       code,
    output logic             code_ext,
    output logic             code_rel,
    output logic             err
);

    localparam int            MW       = RW + CW;
    localparam int            FW       = $clog2(FILT) + 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT - 1);
    localparam logic [RW:0]   ROWS_L   = (RW + 1)'(ROWS);
    localparam logic [CW:0]   COLS_L   = (CW + 1)'(COLS);

    // Input conditioning: bit 0 is kclk, bit 1 is kdat.
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          kclk_d;
    logic          fall;

    // Frame receiver.
    logic [3:0]        bit_cnt;
    logic [9:0]        sr;
    logic [TOUT_W-1:0] tout;
    logic              frame_vld;
    logic [7:0]        frame_byte;
    logic              frame_ok;

    // Prefix decoder.
    logic       ext, rel;
    logic [2:0] skip;
    logic       clr_all;

    // Lookup.
    logic [MW-1:0] map_ram [512];
    logic [MW-1:0] lk_data;
    logic          lk_vld, lk_rel;
    logic [RW-1:0] lk_row;
    logic [CW-1:0] lk_col;
    logic          hit;

    logic [COLS-1:0] matrix [2**RW];

    // Two-flop synchronisers followed by a FILT-clock stability filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            kclk_d <= 1'b0;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1  <= {kdat, kclk};
            sync2  <= sync1;
            kclk_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_MAX) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = kclk_d & ~filt[0];

    // After ten shifts sr holds {parity, data[7:0], start}; stop is the live bit.
    assign frame_ok = ~sr[0] & filt[1] & (^sr[9:1]);

    // Shift frame bits on filtered falling edges; abort partial frames on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            sr         <= '0;
            tout       <= '0;
            frame_vld  <= 1'b0;
            frame_byte <= '0;
            err        <= 1'b0;
        end else begin
            frame_vld <= 1'b0;
            err       <= 1'b0;
            if (fall) begin
                tout <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        frame_vld  <= 1'b1;
                        frame_byte <= sr[8:1];
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    sr      <= {filt[1], sr[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (tout != '1) begin
                tout <= tout + 1'b1;
            end else if (bit_cnt != '0) begin
                bit_cnt <= '0;
                err     <= 1'b1;
            end
        end
    end

    assign clr_all = frame_vld && (skip == 3'd0) &&
                     (frame_byte == 8'hAA || frame_byte == 8'h00 || frame_byte == 8'hFF);

    // Prefix handling, Pause-sequence skipping and the decoded-code strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext      <= 1'b0;
            rel      <= 1'b0;
            skip     <= '0;
            code_vld <= 1'b0;
            resetk   <= 1'b0;
            code     <= '0;
            code_ext <= 1'b0;
            code_rel <= 1'b0;
        end else begin
            code_vld <= 1'b0;
            resetk   <= 1'b0;
            if (frame_vld) begin
                if (skip != 3'd0) begin
                    skip <= skip - 3'd1;
                end else begin
                    case (frame_byte)
                        8'hE0: ext  <= 1'b1;
                        8'hF0: rel  <= 1'b1;
                        8'hE1: skip <= 3'd7;
                        8'hAA, 8'h00, 8'hFF: begin
                            ext <= 1'b0;
                            rel <= 1'b0;
                        end
                        default: begin
                            code_vld <= 1'b1;
                            code     <= frame_byte;
                            code_ext <= ext;
                            code_rel <= rel;
                            resetk   <= (frame_byte == RESET_CODE) && (ext == RESET_EXT) && !rel;
                            ext      <= 1'b0;
                            rel      <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Map RAM, read-first. Entries are stored inverted so that zeroed
    // configuration memory reads back as all-ones (unmapped).
    always_ff @(posedge clk) begin
        if (map_we) map_ram[map_addr] <= ~map_data;
        lk_data <= ~map_ram[{code_ext, code}];
    end

    // Track which lookup result belongs to a decoded code.
    always_ff @(posedge clk) begin
        if (reset) begin
            lk_vld <= 1'b0;
            lk_rel <= 1'b0;
        end else begin
            lk_vld <= code_vld;
            lk_rel <= code_rel;
        end
    end

    assign lk_row = lk_data[MW-1:CW];
    assign lk_col = lk_data[CW-1:0];
    assign hit    = lk_vld && (lk_data != '1) &&
                    ({1'b0, lk_row} < ROWS_L) && ({1'b0, lk_col} < COLS_L);

    // Key matrix: press writes 0, release writes 1; AA/00/FF releases all.
    always_ff @(posedge clk) begin
        if (reset || clr_all) begin
            for (int r = 0; r < 2**RW; r++) matrix[r] <= '1;
        end else if (hit) begin
            matrix[lk_row][lk_col] <= lk_rel;
        end
    end

    assign row = ({1'b0, a} < ROWS_L) ? matrix[a] : '1;

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Directed testbench for ps2_matrix_kbd.
module tb_ps2_matrix_kbd;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kclk = 1'b1;
    logic       kdat = 1'b1;
    logic [3:0] a = '0;
    logic [7:0] row;
    logic       map_we = 1'b0;
    logic [8:0] map_addr = '0;
    logic [6:0] map_data = '0;
    logic       resetk, code_vld, code_ext, code_rel, err;
    logic [7:0] code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int vld_cyc = 0;
    int row_chg_cyc = 0;
    int err_cnt = 0;
    int resetk_cnt = 0;
    int resetk_bad = 0;
    int exp_total = 0;
    logic [7:0] row_prev = '1;
    logic [9:0] exp_q[$];

    ps2_matrix_kbd dut (
        .clk(clk), .reset(reset), .kclk(kclk), .kdat(kdat),
        .a(a), .row(row),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
        .resetk(resetk), .code_vld(code_vld), .code(code),
        .code_ext(code_ext), .code_rel(code_rel), .err(err)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every decoded code is compared with the expected queue.
    always @(negedge clk) begin
        logic [9:0] exp_w;
        if (code_vld) begin
            vld_cnt <= vld_cnt + 1;
            vld_cyc <= cyc;
            if (exp_q.size() == 0) begin
                check("code_unexpected", exp_q.size(), 1);
            end else begin
                exp_w = exp_q.pop_front();
                check("code", {22'd0, code_rel, code_ext, code}, {22'd0, exp_w});
            end
        end
        if (err) err_cnt <= err_cnt + 1;
        if (resetk) begin
            resetk_cnt <= resetk_cnt + 1;
            if (!code_vld) resetk_bad <= resetk_bad + 1;
        end
        if (row !== row_prev) row_chg_cyc <= cyc;
        row_prev <= row;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_code(input logic rel_b, input logic ext_b, input logic [7:0] c);
        exp_q.push_back({rel_b, ext_b, c});
        exp_total++;
    endtask

    task automatic map_write(input logic [8:0] ad, input logic [6:0] d);
        @(negedge clk);
        map_we = 1'b1; map_addr = ad; map_data = d;
        @(negedge clk);
        map_we = 1'b0;
    endtask

    // Sends the first n bits of a frame, LSB (start bit) first.
    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            kdat = fr[i];
            idle(HALF);
            kclk = 1'b0;
            idle(HALF);
            kclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bits({1'b1, p, b, 1'b0}, 11);
        idle(30);
    endtask

    task automatic check_row(input string tag, input logic [3:0] aa, input logic [7:0] exp);
        @(negedge clk);
        a = aa;
        #1;
        check(tag, {24'd0, row}, {24'd0, exp});
    endtask

    initial begin
        // Reset state.
        idle(5);
        check("rst_code_vld", {31'd0, code_vld}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_resetk", {31'd0, resetk}, 0);
        check("rst_code", {21'd0, code_ext, code_rel, code}, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(20);
        check_row("rst_row0", 4'd0, 8'hFF);
        check_row("rst_row9", 4'd9, 8'hFF);
        check_row("rst_row15", 4'd15, 8'hFF);

        map_write({1'b0, 8'h1C}, {4'd6, 3'd5});
        map_write({1'b1, 8'h75}, {4'd0, 3'd0});
        map_write({1'b0, 8'h75}, {4'd9, 3'd2});
        map_write({1'b0, 8'h7E}, 7'h7F);
        map_write({1'b1, 8'h7E}, 7'h7F);

        // Press and release of a plain key, with lookup latency.
        @(negedge clk);
        a = 4'd6;
        expect_code(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0);
        check_row("press_1c", 4'd6, 8'hDF);
        check("latency", row_chg_cyc - vld_cyc, 2);
        expect_code(1'b1, 1'b0, 8'h1C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_row("release_1c", 4'd6, 8'hFF);

        // Extended versus plain mapping of the same scancode.
        expect_code(1'b0, 1'b1, 8'h75);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_row("ext75_row0", 4'd0, 8'hFE);
        check_row("ext75_row9", 4'd9, 8'hFF);
        expect_code(1'b0, 1'b0, 8'h75);
        send_frame(8'h75, 1'b0);
        check_row("plain75_row9", 4'd9, 8'hFB);

        // Parity error, then recovery.
        send_frame(8'h1C, 1'b1);
        check("parity_err", err_cnt, 1);
        check_row("parity_row6", 4'd6, 8'hFF);
        expect_code(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0);
        check_row("after_parity_row6", 4'd6, 8'hDF);

        // Partial frame timeout, glitches, then a clean frame.
        send_bits({1'b1, ~(^8'h1C), 8'h1C, 1'b0}, 6);
        idle(4200);
        check("timeout_err", err_cnt, 2);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            kclk = 1'b0;
            idle(3);
            kclk = 1'b1;
            idle(20);
        end
        expect_code(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0);
        check("glitch_no_err", err_cnt, 2);
        check_row("glitch_row6", 4'd6, 8'hDF);

        // AA releases all held keys.
        send_frame(8'hAA, 1'b0);
        check_row("aa_row0", 4'd0, 8'hFF);
        check_row("aa_row6", 4'd6, 8'hFF);
        check_row("aa_row9", 4'd9, 8'hFF);

        // Pause sequence is swallowed; the byte after it decodes.
        expect_code(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0);
        check_row("pre_pause_row6", 4'd6, 8'hDF);
        send_frame(8'hE1, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'h77, 1'b0);
        send_frame(8'hE1, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h77, 1'b0);
        check("pause_no_vld", vld_cnt, exp_total);
        check_row("pause_row6", 4'd6, 8'hDF);
        expect_code(1'b1, 1'b0, 8'h1C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_row("post_pause_row6", 4'd6, 8'hFF);

        // Reset key.
        expect_code(1'b0, 1'b0, 8'h7E);
        send_frame(8'h7E, 1'b0);
        check("resetk_press", resetk_cnt, 1);
        expect_code(1'b1, 1'b0, 8'h7E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h7E, 1'b0);
        check("resetk_release", resetk_cnt, 1);
        expect_code(1'b0, 1'b0, 8'h7E);
        send_frame(8'h7E, 1'b0);
        check("resetk_repeat", resetk_cnt, 2);
        expect_code(1'b0, 1'b1, 8'h7E);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h7E, 1'b0);
        check("resetk_ext", resetk_cnt, 2);
        check("resetk_coincident", resetk_bad, 0);

        // Reset in the middle of a frame.
        expect_code(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0);
        check_row("pre_reset_row6", 4'd6, 8'hDF);
        send_bits({1'b1, ~(^8'h75), 8'h75, 1'b0}, 6);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        #1;
        check("reset_code", {21'd0, code_ext, code_rel, code}, 0);
        idle(20);
        check_row("reset_row6", 4'd6, 8'hFF);
        check_row("reset_row9", 4'd9, 8'hFF);
        idle(4200);
        check("reset_no_timeout", err_cnt, 2);
        expect_code(1'b0, 1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0);
        check_row("map_retained", 4'd6, 8'hDF);

        // Final bookkeeping.
        idle(5);
        check("vld_total", vld_cnt, exp_total);
        check("exp_q_empty", exp_q.size(), 0);
        check("err_total", err_cnt, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_matrix_kbd.md
Name: ps2_matrix_kbd

Overview:
- Parametrised PS/2-keyboard-to-switching-matrix emulator: the successor of the fixed 10x8 keyboard block.
- Receives PS/2 frames with parity checking, a glitch filter and a timeout.
- Decodes E0/F0/E1 prefixes and maps {ext, scancode} through a host-loadable map RAM to a matrix bit.
- Maintains a ROWS x COLS active-low key matrix read by the emulated machine's row scanner; also emits a reset-key pulse and a decoded-code strobe.

Parameters:
- ROWS, 10: matrix rows; must satisfy ROWS < 2**RW.
- COLS, 8: matrix columns (bits per row); COLS <= 2**CW.
- RW, 4: row address width.
- CW, 3: column index width.
- FILT, 4: clocks a synchronised kclk/kdat level must be stable before it is accepted.
- TOUT_W, 12: timeout counter width; a partial frame is aborted after 2**TOUT_W-1 clocks with no falling kclk edge.
- RESET_CODE, 8'h7E: scancode that produces resetk.
- RESET_EXT, 0: required E0 state for RESET_CODE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- kclk  in  1  PS/2 clock (asynchronous)
- kdat  in  1  PS/2 data (asynchronous)
- a  in  RW  row address from the machine's row scanner
- row  out  COLS  row a of the matrix; 0 = key pressed
- map_we  in  1  map RAM write strobe
- map_addr  in  9  map RAM address {ext, scancode}
- map_data  in  RW+CW  map RAM entry {row, col}; all-ones = unmapped
- resetk  out  1  one-clock pulse on press of the reset key
- code_vld  out  1  one-clock strobe: a non-prefix code has been decoded
- code  out  8  decoded scancode
- code_ext  out  1  E0 prefix was present
- code_rel  out  1  F0 prefix was present (key release)
- err  out  1  one-clock pulse on parity, start or stop error, or on timeout abort

Behaviour:
- Reset:
  - All matrix bits are set to 1.
  - ext, rel, skip count, shift register, filter and timeout counter are cleared.
  - resetk, code_vld and err are 0; code, code_ext and code_rel are 0.
  - The map RAM is not reset. It powers up all-ones (unmapped) and is retained across reset.
  - Reset asserted mid-frame discards the frame.
- Input conditioning:
  - 2-FF synchroniser on kclk and kdat, then a FILT-clock stability filter on each.
  - A frame bit is sampled on the filtered kclk falling edge.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1 (11 bits).
  - The frame completes on the 11th falling edge.
  - Bad start, bad stop or even parity: frame discarded, err pulses, prefix state unchanged.
- Timeout:
  - The counter clears on every falling edge and saturates at all-ones.
  - Reaching all-ones while bits are pending: frame discarded, err pulses once.
  - An idle line never raises err.
- Decode (clock after a valid frame):
  - E0: ext <= 1, no strobe.
  - F0: rel <= 1, no strobe.
  - E1: discard this byte and the next 7 bytes (Pause sequence); no strobe, no matrix change.
  - AA or 00 or FF: all matrix bits set to 1; ext and rel cleared; no strobe.
  - Any other byte: code_vld pulses with code/code_ext/code_rel; ext and rel are then cleared.
- Lookup:
  - At code_vld the map RAM is read at {ext, code}; the read is synchronous, 1 clock.
  - Next clock: if the entry is not all-ones and row < ROWS and col < COLS, matrix[row][col] <= code_rel (press writes 0, release writes 1). Otherwise no write.
  - Latency: valid stop bit sampled -> matrix bit updated 3 clocks later (decode, lookup, write).
- Reset key: resetk pulses in the same clock as code_vld when code == RESET_CODE, code_ext == RESET_EXT and code_rel == 0. Typematic repeats pulse again.
- Map RAM:
  - Write on map_we (clk edge).
  - A write to the address being looked up in the same clock returns the old data (read-first).
- Row read:
  - row = matrix[a], combinational (asynchronous).
  - a >= ROWS returns all 1s.
  - A matrix write is visible on row the clock after it occurs.
- Repeated make of a held key rewrites 0 (idempotent); a release of a key that is not held rewrites 1.

Test Plan:
- Map {0,8'h1C} -> {4'd6, 3'd5}; send 1C -> code_vld with code=1C, ext=0, rel=0; 3 clocks after the stop bit, row(a=6) = 8'hDF. Then send F0 1C -> row(a=6) = 8'hFF, code_rel=1.
- Map {1,8'h75} -> {0, 0} and {0,8'h75} -> {9, 2}; send E0 75 -> row(a=0) = 8'hFE and row(a=9) = 8'hFF; send 75 -> row(a=9) = 8'hFB.
- Frame 1C with even parity -> err pulses once, no code_vld, matrix unchanged; a following valid 1C is accepted.
- Send 6 bits, then idle for 2**TOUT_W clocks -> err once; the next full frame 1C decodes correctly. FILT-1 clock glitches on kclk -> no bit shift.
- Hold three mapped keys, send AA -> all rows 8'hFF. Send E1 14 77 E1 F0 14 F0 77 -> no code_vld, no matrix change.
- Send 7E -> resetk high for exactly 1 clock, coincident with code_vld; F0 7E -> no resetk. Assert reset between bits 5 and 6 of a frame -> all rows 8'hFF, frame dropped, map RAM retained.
